// File: rtl/rpn_exec_ctrl.sv
// RPN calculator key-stream sequencer: turns operand/operator tokens into LIFO stack
// push/pop/peek strobes, runs the ALU on the top two entries and tracks stack depth.
module rpn_exec_ctrl #(
   parameter int DATA_WIDTH  = 4,
   parameter int STACK_DEPTH = 4,
   localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic                  key_is_op,
   input  logic [DATA_WIDTH-1:0] key_data,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic                  stk_peak,
   output logic [DATA_WIDTH-1:0] stk_din,
   input  logic [DATA_WIDTH-1:0] stk_dout,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid,
   output logic                  err_ovf,
   output logic                  err_unf,
   output logic [DEPTH_W-1:0]    depth
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PUSH_K   = 3'd1,
      POP_B    = 3'd2,
      POP_A    = 3'd3,
      EXEC     = 3'd4,
      PUSH_R   = 3'd5,
      PEEK     = 3'd6,
      PEEK_CAP = 3'd7
   } state_t;

   state_t                state_q, state_d;
   logic [DEPTH_W-1:0]    depth_q, depth_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic [DATA_WIDTH-1:0] din_q, din_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [1:0]            opc_q, opc_d;
   logic                  push_q, push_d;
   logic                  pop_q, pop_d;
   logic                  peak_q, peak_d;
   logic                  rv_q, rv_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  accept;

   function automatic logic [DATA_WIDTH-1:0] alu(input logic [1:0] opc,
                                                 input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
      logic [DATA_WIDTH-1:0] r;
      case (opc)
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         2'd2:    r = a * b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   // A pending error/result pulse holds off the next token for one cycle.
   assign key_ready = (state_q == IDLE) && !rv_q && !ovf_q && !unf_q;
   assign accept    = key_valid && key_ready;

   always_comb begin
      state_d  = state_q;
      depth_d  = depth_q;
      result_d = result_q;
      din_d    = din_q;
      b_d      = b_q;
      opc_d    = opc_q;
      push_d   = 1'b0;
      pop_d    = 1'b0;
      peak_d   = 1'b0;
      rv_d     = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (!key_is_op) begin
                  if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                     ovf_d = 1'b1;
                  end else begin
                     state_d = PUSH_K;
                     push_d  = 1'b1;
                     din_d   = key_data;
                     depth_d = depth_q + DEPTH_W'(1);
                  end
               end else begin
                  case (key_data[2:0])
                     3'd0, 3'd1, 3'd2, 3'd3: begin
                        if (depth_q < DEPTH_W'(2)) begin
                           unf_d = 1'b1;
                        end else begin
                           state_d = POP_B;
                           pop_d   = 1'b1;
                           opc_d   = key_data[1:0];
                        end
                     end
                     3'd4: begin
                        if (depth_q == '0) begin
                           unf_d = 1'b1;
                        end else begin
                           state_d = PEEK;
                           peak_d  = 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         PUSH_K: state_d = IDLE;
         POP_B: begin
            state_d = POP_A;
            pop_d   = 1'b1;
         end
         POP_A: begin
            // stk_dout now carries B, popped by the strobe of the previous cycle.
            b_d     = stk_dout;
            state_d = EXEC;
         end
         EXEC: begin
            result_d = alu(opc_q, stk_dout, b_q);
            din_d    = result_d;
            push_d   = 1'b1;
            rv_d     = 1'b1;
            depth_d  = depth_q - DEPTH_W'(1);
            state_d  = PUSH_R;
         end
         PUSH_R: state_d = IDLE;
         PEEK:   state_d = PEEK_CAP;
         PEEK_CAP: begin
            result_d = stk_dout;
            rv_d     = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         depth_q  <= '0;
         result_q <= '0;
         din_q    <= '0;
         b_q      <= '0;
         opc_q    <= '0;
         push_q   <= 1'b0;
         pop_q    <= 1'b0;
         peak_q   <= 1'b0;
         rv_q     <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         depth_q  <= depth_d;
         result_q <= result_d;
         din_q    <= din_d;
         b_q      <= b_d;
         opc_q    <= opc_d;
         push_q   <= push_d;
         pop_q    <= pop_d;
         peak_q   <= peak_d;
         rv_q     <= rv_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   assign stk_push     = push_q;
   assign stk_pop      = pop_q;
   assign stk_peak     = peak_q;
   assign stk_din      = din_q;
   assign result       = result_q;
   assign result_valid = rv_q;
   assign err_ovf      = ovf_q;
   assign err_unf      = unf_q;
   assign depth        = depth_q;

endmodule

// File: tb/tb_rpn_exec_ctrl.sv
// Bench for rpn_exec_ctrl: LIFO stack model on the strobes, a directed token table,
// hand-written reset/overflow sequences and a random token stream against a queue model.
module tb_rpn_exec_ctrl;

   localparam int DW = 4;
   localparam int SD = 4;

   typedef struct {
      bit       is_op;
      bit [3:0] data;
      bit [3:0] exp_result;
      int       exp_depth;
      int       exp_push;
      int       exp_pop;
      int       exp_peak;
      int       exp_rv;
      int       exp_ovf;
      int       exp_unf;
      int       exp_push_cyc;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_valid = 1'b0;
   logic          key_ready;
   logic          key_is_op = 1'b0;
   logic [DW-1:0] key_data = '0;
   logic          stk_push, stk_pop, stk_peak;
   logic [DW-1:0] stk_din;
   logic [DW-1:0] stk_dout;
   logic [DW-1:0] result;
   logic          result_valid, err_ovf, err_unf;
   logic [2:0]    depth;

   int n_pass = 0;
   int n_total = 0;

   rpn_exec_ctrl #(.DATA_WIDTH(DW), .STACK_DEPTH(SD)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_valid(key_valid), .key_ready(key_ready),
      .key_is_op(key_is_op), .key_data(key_data),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_peak(stk_peak),
      .stk_din(stk_din), .stk_dout(stk_dout),
      .result(result), .result_valid(result_valid),
      .err_ovf(err_ovf), .err_unf(err_unf), .depth(depth)
   );

   always #5 clk = ~clk;

   // Stack model; it is cleared together with the DUT to keep both in step.
   logic [DW-1:0] stk_mem [SD];
   int            sp;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sp       <= 0;
         stk_dout <= '0;
      end else if (stk_push && sp < SD) begin
         stk_mem[sp] <= stk_din;
         sp          <= sp + 1;
      end else if (stk_pop && sp > 0) begin
         stk_dout <= stk_mem[sp-1];
         sp       <= sp - 1;
      end else if (stk_peak && sp > 0) begin
         stk_dout <= stk_mem[sp-1];
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
   endtask

   function automatic vec_t mk(bit is_op, bit [3:0] d, bit [3:0] r, int dep, int pu, int po,
                               int pk, int rv, int ov, int un, int pc);
      vec_t v;
      v.is_op = is_op; v.data = d; v.exp_result = r; v.exp_depth = dep;
      v.exp_push = pu; v.exp_pop = po; v.exp_peak = pk; v.exp_rv = rv;
      v.exp_ovf = ov; v.exp_unf = un; v.exp_push_cyc = pc;
      return v;
   endfunction

   function automatic vec_t v_opnd(bit [3:0] d, int dep);
      return mk(0, d, 0, dep, 1, 0, 0, 0, 0, 0, 1);
   endfunction
   function automatic vec_t v_ovf(bit [3:0] d);
      return mk(0, d, 0, SD, 0, 0, 0, 0, 1, 0, 0);
   endfunction
   function automatic vec_t v_arith(bit [3:0] op, bit [3:0] r, int dep);
      return mk(1, op, r, dep, 1, 2, 0, 1, 0, 0, 4);
   endfunction
   function automatic vec_t v_peek(bit [3:0] r, int dep);
      return mk(1, 4'd4, r, dep, 0, 0, 1, 1, 0, 0, 0);
   endfunction
   function automatic vec_t v_unf(bit [3:0] op, int dep);
      return mk(1, op, 0, dep, 0, 0, 0, 0, 0, 1, 0);
   endfunction
   function automatic vec_t v_nop(bit [3:0] op, int dep);
      return mk(1, op, 0, dep, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // Called just after a negedge; returns on the negedge where key_ready is back.
   task automatic run_token(input vec_t v, input string tag);
      int w, cyc, pu, po, pk, rv, ov, un, pc, multi;
      logic [DW-1:0] rres;
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         key_data  = DW'($urandom);
         key_is_op = 1'($urandom);
      end
      w = 0;
      while (!key_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, " ready_wait"}, int'(key_ready), 1);
      key_valid = 1'b1;
      key_is_op = v.is_op;
      key_data  = v.data;
      @(posedge clk);
      cyc = 0; pu = 0; po = 0; pk = 0; rv = 0; ov = 0; un = 0; pc = 0; multi = 0; rres = '0;
      do begin
         @(negedge clk);
         key_valid = 1'b0;
         key_data  = DW'($urandom);
         key_is_op = 1'($urandom);
         cyc++;
         if (stk_push) begin
            pu++;
            if (pc == 0) pc = cyc;
         end
         if (stk_pop) po++;
         if (stk_peak) pk++;
         if (result_valid) begin
            rv++;
            rres = result;
         end
         if (err_ovf) ov++;
         if (err_unf) un++;
         if ((int'(stk_push) + int'(stk_pop) + int'(stk_peak)) > 1) multi++;
      end while (!key_ready && cyc < 20);
      chk({tag, " done"}, int'(cyc < 20), 1);
      chk({tag, " push"}, pu, v.exp_push);
      chk({tag, " pop"}, po, v.exp_pop);
      chk({tag, " peak"}, pk, v.exp_peak);
      chk({tag, " rv"}, rv, v.exp_rv);
      chk({tag, " ovf"}, ov, v.exp_ovf);
      chk({tag, " unf"}, un, v.exp_unf);
      chk({tag, " onehot"}, multi, 0);
      chk({tag, " depth"}, int'(depth), v.exp_depth);
      if (v.exp_push_cyc != 0) chk({tag, " push_cycle"}, pc, v.exp_push_cyc);
      if (v.exp_rv != 0) chk({tag, " result"}, int'(rres), int'(v.exp_result));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      key_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst depth", int'(depth), 0);
      chk("rst result", int'(result), 0);
      chk("rst stk_din", int'(stk_din), 0);
      chk("rst strobes", int'({stk_push, stk_pop, stk_peak}), 0);
      chk("rst pulses", int'({result_valid, err_ovf, err_unf}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst key_ready", int'(key_ready), 1);
   endtask

   vec_t tbl[$];
   int   model_q[$];

   initial begin
      vec_t v;
      tbl.push_back(v_unf(4'd0, 0));
      tbl.push_back(v_opnd(4'd3, 1));
      tbl.push_back(v_opnd(4'd5, 2));
      tbl.push_back(v_arith(4'd0, 4'd8, 1));
      tbl.push_back(v_peek(4'd8, 1));
      tbl.push_back(v_nop(4'd6, 1));
      tbl.push_back(v_opnd(4'd2, 2));
      tbl.push_back(v_opnd(4'd5, 3));
      tbl.push_back(v_arith(4'd1, 4'd13, 2));
      tbl.push_back(v_opnd(4'd7, 3));
      tbl.push_back(v_opnd(4'd3, 4));
      tbl.push_back(v_arith(4'd2, 4'd5, 3));
      tbl.push_back(v_arith(4'd3, 4'd5, 2));
      tbl.push_back(v_opnd(4'd15, 3));
      tbl.push_back(v_opnd(4'd14, 4));
      tbl.push_back(v_ovf(4'd9));
      tbl.push_back(v_arith(4'd0, 4'd13, 3));
      tbl.push_back(v_peek(4'd13, 3));
      tbl.push_back(v_nop(4'd7, 3));

      do_reset();
      for (int i = 0; i < tbl.size(); i++) run_token(tbl[i], $sformatf("tbl%0d", i));

      // Overflow on a fresh stack 1,2,3,4: the top entry must stay 4.
      do_reset();
      for (int i = 1; i <= 4; i++) run_token(v_opnd(4'(i), i), $sformatf("fill%0d", i));
      run_token(v_ovf(4'd9), "ovf9");
      chk("ovf stack top", int'(stk_mem[3]), 4);
      chk("ovf stack count", sp, 4);

      // Reset while the second pop is on the stack port.
      @(negedge clk);
      key_valid = 1'b1; key_is_op = 1'b1; key_data = 4'd0;
      @(posedge clk);
      @(negedge clk);
      key_valid = 1'b0;
      chk("abort pop_b", int'(stk_pop), 1);
      @(negedge clk);
      chk("abort pop_a", int'(stk_pop), 1);
      rst_n = 1'b0;
      #1;
      chk("abort strobes", int'({stk_push, stk_pop, stk_peak}), 0);
      chk("abort depth", int'(depth), 0);
      chk("abort rv", int'(result_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort key_ready", int'(key_ready), 1);
      run_token(v_unf(4'd0, 0), "post_rst_unf");
      run_token(v_opnd(4'd6, 1), "post_rst_push6");
      run_token(v_peek(4'd6, 1), "post_rst_peek");

      // Random token stream against a queue-based model of the stack contents.
      do_reset();
      model_q.delete();
      for (int i = 0; i < 200; i++) begin
         int d, op, a, b, r;
         if ($urandom_range(0, 1) == 0) begin
            d = $urandom_range(0, 15);
            if (model_q.size() == SD) v = v_ovf(4'(d));
            else begin
               model_q.push_back(d);
               v = v_opnd(4'(d), model_q.size());
            end
         end else begin
            op = $urandom_range(0, 7);
            if (op < 4) begin
               if (model_q.size() < 2) v = v_unf(4'(op), model_q.size());
               else begin
                  b = model_q.pop_back();
                  a = model_q.pop_back();
                  case (op)
                     0: r = (a + b) % 16;
                     1: r = (a - b + 16) % 16;
                     2: r = (a * b) % 16;
                     default: r = a & b;
                  endcase
                  model_q.push_back(r);
                  v = v_arith(4'(op), 4'(r), model_q.size());
               end
            end else if (op == 4) begin
               if (model_q.size() == 0) v = v_unf(4'd4, 0);
               else v = v_peek(4'(model_q[$]), model_q.size());
            end else v = v_nop(4'(op), model_q.size());
         end
         run_token(v, $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
